fir_bank_tdm: RTL and testbench
===============================

Name: fir_bank_tdm

Overview:
- Time-multiplexed, runtime-programmable FIR filter bank. It replaces the fixed per-band FIR instances with one shared MAC and one shared sample delay line.
- It computes NUM_BANDS band outputs from one audio input stream. Coefficients are written through a register port instead of being fixed at elaboration.
- It sits between the audio input stage and the per-band gain/mixer stage of the equalizer.

Parameters:
- NUM_BANDS, 10, number of filter bands computed per input sample.
- N, 31, taps per band, shared delay-line depth; must be >= 2.
- DATA_W, 24, signed sample width, in and out.
- COEF_W, 12, signed coefficient width.
- COEF_FRAC, 11, coefficient fractional bits (Q1.11 at default).
- ACC_W, DATA_W+COEF_W+$clog2(N), accumulator width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global enable; when low, new samples are not accepted.
- sample_valid  in  1  one-cycle strobe; audio_in is valid this cycle.
- audio_in  in  DATA_W  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_band  in  $clog2(NUM_BANDS)  band index for the write.
- coef_idx  in  $clog2(N)  tap index for the write.
- coef_data  in  COEF_W  signed coefficient value.
- band_out  out  NUM_BANDS*DATA_W  band b output is at bits [b*DATA_W +: DATA_W].
- out_valid  out  1  one-cycle pulse; all of band_out updated this cycle.
- busy  out  1  high while a computation is in progress.
- overrun  out  1  sticky flag: a sample was dropped.
- coef_err  out  1  sticky flag: a coefficient write was rejected.
- flags_clr  in  1  clears overrun and coef_err.

Behaviour:
- Reset (async, rst_n low):
  - delay line cleared to 0; all coefficients cleared to 0.
  - band_out = 0; out_valid = 0; busy = 0; overrun = 0; coef_err = 0.
  - FSM forced to IDLE.
- Reset asserted mid-computation aborts the computation; no out_valid is produced for that sample.
- Delay line: x[0] is the newest sample, x[N-1] the oldest. On acceptance, the line shifts by one and audio_in is written into x[0] at the same edge.
- Sample acceptance: a sample is accepted when sample_valid && enable && state==IDLE.
- FSM states:
  - IDLE: on acceptance, go to MAC with band=0, tap=0, acc=0.
  - MAC: one multiply-accumulate per cycle, acc += x[tap]*c[band][tap]. After tap N-1, go to STORE.
  - STORE:
    - Compute r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up, arithmetic shift).
    - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and write it to the internal result register for this band.
    - If band < NUM_BANDS-1: band++, tap=0, acc=0, go to MAC.
    - Else: go to DONE.
  - DONE: copy all result registers to band_out at once, pulse out_valid, go to IDLE.
- Latency:
  - out_valid is high exactly L = NUM_BANDS*(N+1)+1 edges after the accepting edge (321 at default).
  - band_out holds its value between updates.
- busy = (state != IDLE). busy is low in the cycle out_valid is high, so back-to-back samples have a period of L+1 cycles.
- Sample while busy: sample_valid && enable && busy drops the sample and sets overrun. The delay line is untouched and the computation continues.
- enable low:
  - sample_valid is ignored, with no overrun.
  - If enable drops mid-computation, the computation completes normally.
- Coefficient writes:
  - Applied in IDLE only; the write lands at the edge.
  - coef_we while busy is ignored and sets coef_err.
  - Out-of-range coef_band or coef_idx is ignored and sets coef_err.
  - A coefficient write and a sample acceptance in the same IDLE cycle: the write takes effect first, so the new coefficient is used.
- Flag priority: a set condition in the same cycle as flags_clr wins.
- Arithmetic: the product is full precision (DATA_W+COEF_W). The accumulator is ACC_W and cannot overflow for any input.

Decomposition:
- Package fir_bank_pkg:
  - FSM state enum (IDLE, MAC, STORE, DONE).
  - ACC_W derivation function.
  - round/saturate function parameterised by width.
- Sub-module fir_mac_round: registered MAC with clear, plus the round/saturate output stage. It is instanced once.
- Top level holds the FSM, the delay line, the coefficient register file and the output registers.

Test Plan:
- Impulse response: load band0 taps c[k]=k+1 and band3 taps c[k]=-(k+1). Input 2048, then 30 zeros. After the m-th sample, band0 must read m+1 and band3 must read -(m+1); other bands read 0. out_valid must arrive 321 cycles after each accept.
- Saturation: load all taps of band1 with 0x7FF. Feed 31 samples of 0x7FFFFF: band1 must read 0x7FFFFF. Feed 31 samples of 0x800000: band1 must read 0x800000.
- Rounding: band2 with tap0=1 and all other taps 0. Required outputs:
  - input 1024 -> 1.
  - input -1024 -> 0.
  - input -1025 -> -1.
  - input 1023 -> 0.
- Overrun and coef_err:
  - Pulse sample_valid 10 cycles after an accept: overrun must go to 1, and the output must be unchanged from the no-drop case.
  - coef_we while busy: coef_err must go to 1 and the coefficient must be unchanged.
  - flags_clr must clear both flags.
- enable gating: with enable=0, sample_valid produces no busy and no overrun. Dropping enable mid-computation must still give out_valid at cycle 321.
- Reset mid-computation: assert rst_n low at cycle 100 of a computation. All outputs must go to 0 immediately with no out_valid. After release, an impulse with zero coefficients must give all-zero band_out.

Source files
------------

// File: rtl/fir_bank_pkg.sv
// rtl/fir_bank_pkg.sv - shared types and arithmetic helpers for the TDM FIR filter bank
package fir_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accumulator wide enough that N full-scale products can never overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int n);
        return data_w + coef_w + $clog2(n);
    endfunction

    // Round half up, drop frac bits (arithmetic), clamp to a signed out_w range.
    // Accumulators up to 64 bits are supported; callers truncate to out_w.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac,
                                                     input int out_w);
        logic signed [63:0] half;
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        half  = (frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0;
        r     = (acc + half) >>> frac;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac_round.sv
// rtl/fir_mac_round.sv - shared registered MAC with clear plus round/saturate output stage
//   clk, rst_n : clock, async active-low reset
//   i_clr      : zero the accumulator at this edge (takes priority over i_en)
//   i_en       : accumulate i_x * i_c at this edge
//   i_x, i_c   : signed sample and coefficient operands
//   o_y        : rounded, saturated view of the current accumulator (combinational)
module fir_mac_round
    import fir_bank_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 12,
    parameter int COEF_FRAC = 11,
    parameter int ACC_W     = 41
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [COEF_W-1:0] i_c,
    output logic signed [DATA_W-1:0] o_y
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [63:0]       w_acc64;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod     = i_x * i_c;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_acc64    = {{(64 - ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign o_y        = DATA_W'(round_sat(w_acc64, COEF_FRAC, DATA_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/fir_bank_tdm.sv
// rtl/fir_bank_tdm.sv - time-multiplexed programmable FIR bank, one MAC shared by all bands
//   sample_valid/enable/audio_in : input stream, accepted only when idle
//   coef_we/coef_band/coef_idx/coef_data : coefficient register writes (idle only)
//   band_out/out_valid : all band results, updated together with a one-cycle pulse
//   busy/overrun/coef_err/flags_clr : status, sticky error flags and their clear
module fir_bank_tdm
    import fir_bank_pkg::*;
#(
    parameter int NUM_BANDS = 10,
    parameter int N         = 31,
    parameter int DATA_W    = 24,
    parameter int COEF_W    = 12,
    parameter int COEF_FRAC = 11
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           sample_valid,
    input  logic signed [DATA_W-1:0]       audio_in,
    input  logic                           coef_we,
    input  logic [$clog2(NUM_BANDS)-1:0]   coef_band,
    input  logic [$clog2(N)-1:0]           coef_idx,
    input  logic signed [COEF_W-1:0]       coef_data,
    output logic [NUM_BANDS*DATA_W-1:0]    band_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic                           coef_err,
    input  logic                           flags_clr
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, N);
    localparam int BW    = $clog2(NUM_BANDS);
    localparam int TW    = $clog2(N);

    state_t                   r_state;
    state_t                   w_next;
    logic [BW-1:0]            r_band;
    logic [TW-1:0]            r_tap;
    logic signed [DATA_W-1:0] r_x    [N];
    logic signed [COEF_W-1:0] r_coef [NUM_BANDS][N];
    logic signed [DATA_W-1:0] r_res  [NUM_BANDS];

    logic                     w_accept;
    logic                     w_drop;
    logic                     w_in_range;
    logic                     w_coef_wr;
    logic                     w_coef_bad;
    logic                     w_last_tap;
    logic                     w_last_band;
    logic signed [DATA_W-1:0] w_y;

    assign busy        = (r_state != IDLE);
    assign w_accept    = sample_valid && enable && (r_state == IDLE);
    assign w_drop      = sample_valid && enable && (r_state != IDLE);
    assign w_in_range  = (int'(coef_band) < NUM_BANDS) && (int'(coef_idx) < N);
    assign w_coef_wr   = coef_we && (r_state == IDLE) && w_in_range;
    assign w_coef_bad  = coef_we && !w_coef_wr;
    assign w_last_tap  = (r_tap == TW'(N - 1));
    assign w_last_band = (r_band == BW'(NUM_BANDS - 1));

    // Accumulator is cleared on acceptance and again in STORE so each band starts from zero.
    fir_mac_round #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .COEF_FRAC (COEF_FRAC),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept || (r_state == STORE)),
        .i_en  (r_state == MAC),
        .i_x   (r_x[r_tap]),
        .i_c   (r_coef[r_band][r_tap]),
        .o_y   (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = MAC;
            MAC:     if (w_last_tap) w_next = STORE;
            STORE:   w_next = w_last_band ? DONE : MAC;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_band <= '0;
            r_tap  <= '0;
        end else if (w_accept) begin
            r_band <= '0;
            r_tap  <= '0;
        end else if (r_state == MAC) begin
            r_tap <= w_last_tap ? '0 : r_tap + TW'(1);
        end else if (r_state == STORE && !w_last_band) begin
            r_band <= r_band + BW'(1);
        end
    end

    // Delay line and coefficient file; a same-cycle write lands before the first MAC reads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_x[k] <= '0;
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                for (int k = 0; k < N; k++) begin
                    r_coef[b][k] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                r_x[0] <= audio_in;
                for (int k = 1; k < N; k++) begin
                    r_x[k] <= r_x[k-1];
                end
            end
            if (w_coef_wr) begin
                r_coef[coef_band][coef_idx] <= coef_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_res[b] <= '0;
            end
            band_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (r_state == DONE);
            if (r_state == STORE) begin
                r_res[r_band] <= w_y;
            end
            if (r_state == DONE) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    band_out[b*DATA_W +: DATA_W] <= r_res[b];
                end
            end
        end
    end

    // A new error event in the same cycle as flags_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            coef_err <= 1'b0;
        end else begin
            if (w_drop) begin
                overrun <= 1'b1;
            end else if (flags_clr) begin
                overrun <= 1'b0;
            end
            if (w_coef_bad) begin
                coef_err <= 1'b1;
            end else if (flags_clr) begin
                coef_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_bank_tdm.sv
// tb/tb_fir_bank_tdm.sv - self-checking bench for fir_bank_tdm against an arithmetic reference model
module tb_fir_bank_tdm;

    localparam int NB  = 10;
    localparam int N   = 31;
    localparam int DW  = 24;
    localparam int CW  = 12;
    localparam int FR  = 11;
    localparam int LAT = NB * (N + 1) + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 sample_valid;
    logic signed [DW-1:0] audio_in;
    logic                 coef_we;
    logic [3:0]           coef_band;
    logic [4:0]           coef_idx;
    logic signed [CW-1:0] coef_data;
    logic [NB*DW-1:0]     band_out;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;
    logic                 coef_err;
    logic                 flags_clr;

    int vectors     = 0;
    int miscompares = 0;
    int hist  [N];
    int coefm [NB][N];

    fir_bank_tdm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .coef_we      (coef_we),
        .coef_band    (coef_band),
        .coef_idx     (coef_idx),
        .coef_data    (coef_data),
        .band_out     (band_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .coef_err     (coef_err),
        .flags_clr    (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: y_b = sat(floor((sum_k x[k]*c_b[k] + 2^(FR-1)) / 2^FR)).
    function automatic logic [DW-1:0] model_band(input int b);
        longint acc;
        longint r;
        longint hi;
        longint lo;
        acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(hist[k]) * longint'(coefm[b][k]);
        r  = (acc + (longint'(1) << (FR - 1))) >>> FR;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(hi + 1);
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] to_dw(input int v);
        return v[DW-1:0];
    endfunction

    task automatic push(input int x);
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) hist[k] = 0;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < N; k++) coefm[b][k] = 0;
    endtask

    task automatic wcoef(input int b, input int i, input int v);
        logic signed [CW-1:0] t;
        @(negedge clk);
        coef_we   = 1'b1;
        coef_band = b[3:0];
        coef_idx  = i[4:0];
        coef_data = v[CW-1:0];
        @(negedge clk);
        coef_we = 1'b0;
        t = v[CW-1:0];
        if (b < NB && i < N) coefm[b][i] = t;
    endtask

    task automatic check_all(input string tag);
        for (int b = 0; b < NB; b++)
            chk($sformatf("%s_band%0d", tag, b), {40'b0, band_out[b*DW +: DW]}, {40'b0, model_band(b)});
    endtask

    // One accepted sample; optional in-flight drop pulse, rejected coef write, enable drop,
    // and a band2/tap0 coefficient write in the accepting cycle (same_wr >= 0).
    task automatic run_sample(input int x, input int drop_at, input int cwe_at,
                              input int enlow_at, input int same_wr, input string tag);
        int  k;
        bit  got;
        logic signed [CW-1:0] t;
        @(negedge clk);
        enable       = 1'b1;
        sample_valid = 1'b1;
        audio_in     = x[DW-1:0];
        if (same_wr >= 0) begin
            coef_we   = 1'b1;
            coef_band = 4'd2;
            coef_idx  = 5'd0;
            coef_data = same_wr[CW-1:0];
            t = same_wr[CW-1:0];
            coefm[2][0] = t;
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        coef_we      = 1'b0;
        chk({tag, "_accept_busy"}, {63'b0, busy}, 64'd1);
        push(x);
        k   = 0;
        got = 1'b0;
        while (!got && k < LAT + 20) begin
            @(posedge clk);
            k++;
            #1;
            sample_valid = 1'b0;
            coef_we      = 1'b0;
            if (out_valid) begin
                got = 1'b1;
            end else begin
                if (k == drop_at) begin
                    sample_valid = 1'b1;
                    audio_in     = DW'($urandom);
                end
                if (k == cwe_at) begin
                    coef_we   = 1'b1;
                    coef_band = 4'd0;
                    coef_idx  = 5'd0;
                    coef_data = 12'sh123;
                end
                if (k == enlow_at) enable = 1'b0;
            end
        end
        chk({tag, "_latency"}, 64'(k), 64'(LAT));
        chk({tag, "_busy_at_valid"}, {63'b0, busy}, 64'd0);
        enable = 1'b1;
        check_all(tag);
    endtask

    initial begin
        logic signed [DW-1:0] xs;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        audio_in     = '0;
        coef_we      = 1'b0;
        coef_band    = '0;
        coef_idx     = '0;
        coef_data    = '0;
        flags_clr    = 1'b0;
        model_clear();

        #12;
        chk("rst_band_out", {{(64 - NB*DW + NB*DW){1'b0}}, 64'(band_out != '0)}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_overrun", {63'b0, overrun}, 64'd0);
        chk("rst_coef_err", {63'b0, coef_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse response: band0 c[k]=k+1, band3 c[k]=-(k+1).
        for (int k = 0; k < N; k++) begin
            wcoef(0, k, k + 1);
            wcoef(3, k, -(k + 1));
        end
        for (int m = 0; m < N; m++) begin
            run_sample((m == 0) ? 2048 : 0, 0, 0, 0, -1, $sformatf("imp%0d", m));
            chk($sformatf("imp%0d_b0", m), {40'b0, band_out[0 +: DW]}, {40'b0, to_dw(m + 1)});
            chk($sformatf("imp%0d_b3", m), {40'b0, band_out[3*DW +: DW]}, {40'b0, to_dw(-(m + 1))});
        end

        // Drop while busy and coefficient write while busy.
        run_sample(5000, 10, 20, 0, -1, "ovr");
        chk("ovr_flag", {63'b0, overrun}, 64'd1);
        chk("cerr_flag", {63'b0, coef_err}, 64'd1);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        chk("clr_overrun", {63'b0, overrun}, 64'd0);
        chk("clr_coef_err", {63'b0, coef_err}, 64'd0);

        // Out-of-range coefficient addresses.
        wcoef(10, 0, 5);
        chk("oor_band_err", {63'b0, coef_err}, 64'd1);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        wcoef(0, 31, 5);
        chk("oor_idx_err", {63'b0, coef_err}, 64'd1);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;

        // enable low: samples ignored with no overrun.
        @(negedge clk);
        enable       = 1'b0;
        sample_valid = 1'b1;
        audio_in     = 24'sd99999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("en_low_busy%0d", i), {63'b0, busy}, 64'd0);
        end
        sample_valid = 1'b0;
        chk("en_low_overrun", {63'b0, overrun}, 64'd0);
        run_sample(-7000, 60, 0, 50, -1, "en_drop");
        chk("en_drop_overrun", {63'b0, overrun}, 64'd0);

        // Saturation on band1.
        for (int k = 0; k < N; k++) wcoef(1, k, 12'h7FF);
        for (int m = 0; m < N; m++) run_sample(8388607, 0, 0, 0, -1, $sformatf("satp%0d", m));
        chk("sat_pos", {40'b0, band_out[DW +: DW]}, {40'b0, 24'h7FFFFF});
        for (int m = 0; m < N; m++) run_sample(-8388608, 0, 0, 0, -1, $sformatf("satn%0d", m));
        chk("sat_neg", {40'b0, band_out[DW +: DW]}, {40'b0, 24'h800000});

        // Rounding on band2 (tap0 = 1 LSB of Q1.11).
        wcoef(2, 0, 1);
        run_sample(1024, 0, 0, 0, -1, "rnd_p1024");
        chk("rnd_p1024_b2", {40'b0, band_out[2*DW +: DW]}, {40'b0, 24'h000001});
        run_sample(-1024, 0, 0, 0, -1, "rnd_m1024");
        chk("rnd_m1024_b2", {40'b0, band_out[2*DW +: DW]}, {40'b0, 24'h000000});
        run_sample(-1025, 0, 0, 0, -1, "rnd_m1025");
        chk("rnd_m1025_b2", {40'b0, band_out[2*DW +: DW]}, {40'b0, 24'hFFFFFF});
        run_sample(1023, 0, 0, 0, -1, "rnd_p1023");
        chk("rnd_p1023_b2", {40'b0, band_out[2*DW +: DW]}, {40'b0, 24'h000000});

        // Coefficient write in the accepting cycle is used by that sample.
        run_sample(1024, 0, 0, 0, 4, "same_wr");
        chk("same_wr_b2", {40'b0, band_out[2*DW +: DW]}, {40'b0, 24'h000002});

        // Randomised coefficients and samples.
        for (int b = 4; b < NB; b++)
            for (int k = 0; k < N; k++) wcoef(b, k, int'($urandom));
        for (int m = 0; m < 20; m++) begin
            if (m % 5 == 4) wcoef(5, int'($urandom_range(0, N - 1)), int'($urandom));
            xs = DW'($urandom);
            run_sample(int'(xs), 0, 0, 0, -1, $sformatf("rnd%0d", m));
        end

        // Reset in the middle of a computation.
        @(negedge clk);
        enable       = 1'b1;
        sample_valid = 1'b1;
        audio_in     = 24'sd777;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_band_out", 64'(band_out != '0), 64'd0);
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst_no_valid%0d", i), {63'b0, out_valid}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sample(2048, 0, 0, 0, -1, "post_rst");
        chk("post_rst_b0", {40'b0, band_out[0 +: DW]}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
